// File: rtl/bsg_encode_one_hot.sv
// rtl/bsg_encode_one_hot.sv - one-hot to binary index encoder
// An all-zero input gives index 0. Width is expected to be a power of two.
module bsg_encode_one_hot #(
    parameter int width_p    = 8,
    parameter int lg_width_p = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic [width_p-1:0]    i,
    output logic [lg_width_p-1:0] addr_o
);

    always_comb begin
        addr_o = '0;
        for (int k = 0; k < width_p; k++) begin
            if (i[k]) begin
                addr_o = addr_o | lg_width_p'(k);
            end
        end
    end

endmodule

// File: rtl/bsg_arb_rr_hold_encode.sv
// rtl/bsg_arb_rr_hold_encode.sv - round-robin arbiter with held one-hot grant and binary tag
// The grant is held until yumi_i; the requester served last has lowest priority on re-arbitration.
module bsg_arb_rr_hold_encode #(
    parameter int inputs_p = 8,
    localparam int lg_inputs_p = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [inputs_p-1:0]    reqs_i,
    output logic [inputs_p-1:0]    grants_one_hot_o,
    output logic [lg_inputs_p-1:0] tag_o,
    output logic                   v_o,
    input  logic                   yumi_i
);

    localparam int pad_lp = 1 << lg_inputs_p;

    logic [inputs_p-1:0]    grants_q, grants_d;
    logic [lg_inputs_p-1:0] last_q, last_d;
    logic [lg_inputs_p-1:0] last_sel, win_idx;
    logic [2*inputs_p-1:0]  reqs_dbl;
    logic [pad_lp-1:0]      grants_pad;
    logic                   arb_en;
    logic                   found;

    assign grants_one_hot_o = grants_q;
    assign v_o              = |grants_q;
    assign grants_pad       = pad_lp'(grants_q);

    bsg_encode_one_hot #(
        .width_p    (pad_lp),
        .lg_width_p (lg_inputs_p)
    ) u_encode (
        .i      (grants_pad),
        .addr_o (tag_o)
    );

    // Doubled request vector: the first set bit strictly above last_sel is the
    // next requester in wrap-around order, with last_sel itself considered last.
    always_comb begin
        last_sel = v_o ? tag_o : last_q;
        arb_en   = v_o ? yumi_i : (|reqs_i);
        reqs_dbl = {reqs_i, reqs_i};
        found    = 1'b0;
        win_idx  = '0;
        for (int k = 0; k < 2*inputs_p; k++) begin
            if (!found && (k > int'(last_sel)) && reqs_dbl[k]) begin
                found   = 1'b1;
                win_idx = lg_inputs_p'(k % inputs_p);
            end
        end

        grants_d = grants_q;
        last_d   = last_q;
        if (arb_en) begin
            grants_d = '0;
            if (found) begin
                grants_d[win_idx] = 1'b1;
                last_d            = win_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grants_q <= '0;
            last_q   <= lg_inputs_p'(inputs_p - 1);
        end else begin
            grants_q <= grants_d;
            last_q   <= last_d;
        end
    end

    ap_grant_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(grants_one_hot_o));

    ap_valid_matches: assert property (@(posedge clk_i) disable iff (reset_i)
        v_o == (|grants_one_hot_o));

    ap_no_yumi_idle: assert property (@(posedge clk_i) disable iff (reset_i)
        !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_arb_rr_hold_encode.sv
// tb/tb_bsg_arb_rr_hold_encode.sv - directed self-checking bench for bsg_arb_rr_hold_encode
module tb_bsg_arb_rr_hold_encode;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] reqs8;
    logic [7:0] grants8;
    logic [2:0] tag8;
    logic       v8;
    logic       yumi8;
    logic [4:0] reqs5;
    logic [4:0] grants5;
    logic [2:0] tag5;
    logic       v5;
    logic       yumi5;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bsg_arb_rr_hold_encode #(.inputs_p(8)) dut8 (
        .clk_i            (clk),
        .reset_i          (rst),
        .reqs_i           (reqs8),
        .grants_one_hot_o (grants8),
        .tag_o            (tag8),
        .v_o              (v8),
        .yumi_i           (yumi8)
    );

    bsg_arb_rr_hold_encode #(.inputs_p(5)) dut5 (
        .clk_i            (clk),
        .reset_i          (rst),
        .reqs_i           (reqs5),
        .grants_one_hot_o (grants5),
        .tag_o            (tag5),
        .v_o              (v5),
        .yumi_i           (yumi5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; reqs8 = 8'hFF; yumi8 = 1'b0; reqs5 = '0; yumi5 = 1'b0;

        // reset state with all requests pending
        tick();
        chk("rst_v8", v8, 0);
        chk("rst_grant8", grants8, 0);
        chk("rst_tag8", tag8, 0);
        chk("rst_v5", v5, 0);
        rst = 1'b0;

        // all requesting, yumi every cycle: 0..7 then wrap to 0
        tick();
        chk("rr_first_tag", tag8, 0);
        chk("rr_first_v", v8, 1);
        chk("rr_first_grant", grants8, 8'h01);
        yumi8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rr_seq_tag", tag8, k % 8);
            chk("rr_seq_v", v8, 1);
        end

        // async reset mid-grant
        #2;
        rst = 1'b1; yumi8 = 1'b0; reqs8 = 8'b0010_0100;
        #1;
        chk("arst_v8", v8, 0);
        chk("arst_grant8", grants8, 0);
        #2;
        rst = 1'b0;

        // hold with two requesters, no yumi
        tick();
        chk("hold_grant", grants8, 8'h04);
        chk("hold_tag", tag8, 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_stable", grants8, 8'h04);
        end
        yumi8 = 1'b1;
        tick();
        chk("hold_next_grant", grants8, 8'h20);
        chk("hold_next_tag", tag8, 5);

        // sole requester re-granted with no bubble
        reqs8 = 8'h08;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("solo_tag", tag8, 3);
            chk("solo_v", v8, 1);
        end
        reqs8 = 8'h00;
        tick();
        yumi8 = 1'b0;
        chk("solo_drop_v", v8, 0);
        chk("solo_drop_grant", grants8, 0);

        // grant persists after its request drops
        reqs8 = 8'h40;
        tick();
        chk("req6_grant", grants8, 8'h40);
        reqs8 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("req6_persist", grants8, 8'h40);
            chk("req6_tag", tag8, 6);
        end
        yumi8 = 1'b1;
        tick();
        yumi8 = 1'b0;
        chk("req6_release", v8, 0);

        // inputs_p=5: rotation with wrap 4 -> 0
        reqs5 = 5'h1F;
        tick();
        chk("p5_first", tag5, 0);
        yumi5 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("p5_seq_tag", tag5, k % 5);
            chk("p5_tag_range", (tag5 <= 3'd4), 1);
        end
        chk("p5_wrap_grant", grants5, 5'h01);
        yumi5 = 1'b0;
        tick();
        chk("p5_held", tag5, 0);

        // async reset mid-grant, then priority restarts at requester 0
        #2;
        rst = 1'b1;
        #1;
        chk("p5_arst_v", v5, 0);
        chk("p5_arst_grant", grants5, 0);
        chk("p5_arst_tag", tag5, 0);
        reqs5 = 5'b10010;
        #3;
        rst = 1'b0;
        tick();
        chk("p5_restart_tag", tag5, 1);
        chk("p5_restart_grant", grants5, 5'b00010);
        yumi5 = 1'b1;
        tick();
        chk("p5_after_tag", tag5, 4);
        yumi5 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
